shift_mult_ctrl: RTL and testbench

//  Sequencing controller and accumulator for the radix-2 shift-add multiplier.

---
 rtl/shift_mult_pkg.sv | 21 ++
 rtl/shift_mult_dp.sv | 37 +++
 rtl/shift_mult_ctrl.sv | 102 ++++++++++
 tb/tb_shift_mult_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/shift_mult_pkg.sv
// Shared types and constants for the radix-2 shift-add multiplier slice.
package shift_mult_pkg;

   localparam int unsigned N_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Ceiling log2, used to size the step counter from N.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/shift_mult_dp.sv
// Operand shifter: holds a shifted multiplicand and multiplier, emits the gated partial product.
module shift_mult_dp
   import shift_mult_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           en,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] pp_c
);

   localparam int unsigned PW = 2 * N;

   logic [PW-1:0] a_s;
   logic [N-1:0]  b_s;

   // start loads fresh operands; en advances one bit of the multiplier per cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_s <= '0;
         b_s <= '0;
      end else if (start) begin
         a_s <= PW'(a);
         b_s <= b;
      end else if (en) begin
         a_s <= a_s << 1;
         b_s <= b_s >> 1;
      end
   end

   assign pp_c = b_s[0] ? a_s : '0;

endmodule

// File: rtl/shift_mult_ctrl.sv
// Sequencing controller and accumulator for the shift-add multiplier, valid/ready on both sides.
module shift_mult_ctrl
   import shift_mult_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] product,
   output logic           busy
);

   localparam int unsigned CNT_W = clog2(N + 1);
   localparam int unsigned PW    = 2 * N;

   state_t             state;
   logic [N-1:0]       a_q;
   logic [N-1:0]       b_q;
   logic [CNT_W-1:0]   cnt;
   logic [PW-1:0]      acc;
   logic [PW-1:0]      pp;
   logic [PW-1:0]      acc_nxt;
   logic               dp_start;
   logic               dp_en;

   // Shifter controls are decoded from state so start and en are mutually exclusive.
   assign dp_start = (state == LOAD);
   assign dp_en    = (state == RUN);
   assign acc_nxt  = acc + pp;
   assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);

   shift_mult_dp #(.N(N)) u_dp (
      .clk   (clk),
      .rst_n (rst_n),
      .start (dp_start),
      .en    (dp_en),
      .a     (a_q),
      .b     (b_q),
      .pp_c  (pp)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt       <= '0;
         acc       <= '0;
         product   <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= a;
                  b_q   <= b;
                  busy  <= 1'b1;
                  state <= LOAD;
               end
            end
            LOAD: begin
               acc   <= '0;
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(N - 1)) begin
                  product   <= acc_nxt;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: begin
               // A new pair may be taken in the same cycle the result drains.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     a_q   <= a;
                     b_q   <= b;
                     busy  <= 1'b1;
                     state <= LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_mult_ctrl.sv
// Directed and randomized checks of shift_mult_ctrl against hand-computed products.
module tb_shift_mult_ctrl;

   localparam int unsigned N = 4;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-1:0] product;
   logic           busy;

   int n_checks;
   int n_errors;

   shift_mult_ctrl #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one pair at a negedge and let it be accepted on the following posedge.
   task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
      @(negedge clk);
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      #1;
      check("accept_ready", 16'(in_ready), 16'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Cycles 1..N+3 after accept with out_ready high: one-cycle out_valid at N+2, busy in 1..N+1.
   task automatic observe(input string tag, input logic [15:0] exp_prod);
      logic [6:0] ov;
      logic [6:0] bz;
      ov = '0;
      bz = '0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         ov[i-1] = out_valid;
         bz[i-1] = busy;
         if (i == 6) check({tag, "_prod"}, 16'(product), exp_prod);
      end
      check({tag, "_ov_seq"}, 16'(ov), 16'b0100000);
      check({tag, "_busy_seq"}, 16'(bz), 16'b0011111);
   endtask

   initial begin
      logic [7:0] q[$];
      int issued;
      int received;
      int cycles;
      logic [7:0] exp_p;

      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_in_ready", 16'(in_ready), 16'd1);
      check("rst_out_valid", 16'(out_valid), 16'd0);
      check("rst_product", 16'(product), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);

      // Basic products and boundary operands, fixed latency
      issue(4'd3, 4'd5);   observe("m3x5", 16'd15);
      issue(4'd15, 4'd15); observe("m15x15", 16'hE1);
      issue(4'd0, 4'd9);   observe("m0x9", 16'd0);
      issue(4'd9, 4'd0);   observe("m9x0", 16'd0);

      // Backpressure: result held, in_valid ignored while in_ready is low
      out_ready = 1'b0;
      issue(4'd5, 4'd2);
      repeat (6) @(negedge clk);
      check("bp_first_valid", 16'(out_valid), 16'd1);
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         a        = 4'd1;
         b        = 4'd1;
         #1;
         check("bp_valid", 16'(out_valid), 16'd1);
         check("bp_prod", 16'(product), 16'd10);
         check("bp_in_ready", 16'(in_ready), 16'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("bp_busy", 16'(busy), 16'd0);
      // Drain and accept in the same cycle: next cycle must already be LOAD
      out_ready = 1'b1;
      issue(4'd2, 4'd7);
      observe("bp_next", 16'd14);

      // Reset in the third cycle after accept (second RUN cycle) discards the operation
      issue(4'd7, 4'd7);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_out_valid", 16'(out_valid), 16'd0);
      check("mrst_product", 16'(product), 16'd0);
      check("mrst_busy", 16'(busy), 16'd0);
      check("mrst_in_ready", 16'(in_ready), 16'd1);
      repeat (8) @(negedge clk);
      check("mrst_no_output", 16'(out_valid), 16'd0);
      issue(4'd6, 4'd9);
      observe("m6x9", 16'd54);

      // Random traffic with a scoreboard in issue order
      issued   = 0;
      received = 0;
      cycles   = 0;
      while (received < 1000 && cycles < 40000) begin
         @(negedge clk);
         cycles++;
         in_valid  = (issued < 1000) && ($urandom_range(0, 1) == 1);
         a         = N'($urandom_range(0, 15));
         b         = N'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rnd_extra", 16'(product), 16'hFFFF);
            end else begin
               exp_p = q.pop_front();
               check("rnd_prod", 16'(product), 16'(exp_p));
            end
            received++;
         end
         if (in_valid && in_ready) begin
            q.push_back(8'(a) * 8'(b));
            issued++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("rnd_received", 16'(received), 16'd1000);
      check("rnd_issued", 16'(issued), 16'd1000);
      check("rnd_queue_empty", 16'(q.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
